// File: rtl/decoder_seq_pkg.sv
// Shared types for the registered one-hot decoder/sequencer.
package decoder_seq_pkg;

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'd0,
    MODE_PULSE = 2'd1,
    MODE_SCAN  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEVEL = 2'd1,
    S_PULSE = 2'd2,
    S_SCAN  = 2'd3
  } state_t;

endpackage

// File: rtl/decoder_seq_n_if.sv
// Command handshake and decoded-output bundle for decoder_seq_n.
interface decoder_seq_n_if #(
  parameter int EncodeWidth = 4,
  parameter int DecodeWidth = 2 ** EncodeWidth,
  parameter int DwellWidth  = 8
);
  logic [EncodeWidth-1:0] IN;
  logic [1:0]             MODE;
  logic [DwellWidth-1:0]  DWELL;
  logic                   VALID;
  logic                   READY;
  logic                   EN;
  logic [DecodeWidth-1:0] OUT;
  logic [EncodeWidth-1:0] IDX;
  logic                   ERR;

  modport master (
    output IN, MODE, DWELL, VALID, EN,
    input  READY, OUT, IDX, ERR
  );

  modport slave (
    input  IN, MODE, DWELL, VALID, EN,
    output READY, OUT, IDX, ERR
  );
endinterface

// File: rtl/decoder_seq_n_dwell_counter.sv
// Loadable dwell down-counter; load wins over decrement, holds at zero.
module dwell_counter #(
  parameter int DwellWidth = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DwellWidth-1:0] load_val,
  input  logic                  en,
  output logic                  zero
);
  logic [DwellWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (en && cnt_q != '0)  cnt_d = cnt_q - DwellWidth'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/decoder_seq_n.sv
// Registered one-hot decoder with level, pulse and timed-scan output modes.
//   state   | meaning
//   S_IDLE  | OUT low, waiting for a command
//   S_LEVEL | OUT = one-hot(IDX) while EN, until next accept
//   S_PULSE | single-cycle one-hot strobe, then IDLE
//   S_SCAN  | walk IDX over every line, DWELL+1 enabled cycles each
module decoder_seq_n
  import decoder_seq_pkg::*;
#(
  parameter int EncodeWidth = 4,
  parameter int DecodeWidth = 2 ** EncodeWidth,
  parameter int DwellWidth  = 8
) (
  input logic          CLK,
  input logic          RST,
  decoder_seq_n_if.slave bus
);
  localparam logic [EncodeWidth:0]   DEC_LIM  = (EncodeWidth+1)'(DecodeWidth);
  localparam logic [EncodeWidth-1:0] LAST_IDX = EncodeWidth'(DecodeWidth - 1);

  state_t                 state_q, state_d;
  logic [EncodeWidth-1:0] idx_q, idx_d, start_q, start_d, idx_step;
  logic [DwellWidth-1:0]  dwell_q, dwell_d, cnt_load_val;
  logic [DecodeWidth-1:0] out_q, out_d;
  logic                   err_q, err_d;
  logic                   ready, accept, illegal, cnt_load, cnt_zero;
  mode_t                  mode_in;

  function automatic logic [DecodeWidth-1:0] onehot(input logic [EncodeWidth-1:0] i);
    return {{(DecodeWidth-1){1'b0}}, 1'b1} << i;
  endfunction

  assign ready    = (state_q != S_SCAN);
  assign accept   = bus.VALID && ready;
  assign mode_in  = mode_t'(bus.MODE);
  assign illegal  = (mode_in == MODE_RSVD) || ({1'b0, bus.IN} >= DEC_LIM);
  assign idx_step = (idx_q == LAST_IDX) ? '0 : idx_q + EncodeWidth'(1);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    start_d      = start_q;
    dwell_d      = dwell_q;
    err_d        = 1'b0;
    out_d        = '0;
    cnt_load     = 1'b0;
    cnt_load_val = dwell_q;
    if (accept) begin
      if (illegal) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        idx_d = bus.IN;
        case (mode_in)
          MODE_LEVEL: state_d = S_LEVEL;
          MODE_PULSE: state_d = S_PULSE;
          default: begin
            state_d      = S_SCAN;
            start_d      = bus.IN;
            dwell_d      = bus.DWELL;
            cnt_load     = 1'b1;
            cnt_load_val = bus.DWELL;
          end
        endcase
      end
    end else begin
      case (state_q)
        S_PULSE: state_d = S_IDLE;
        S_SCAN: begin
          // Lap ends when the next step would land back on the start line.
          if (bus.EN && cnt_zero) begin
            cnt_load = 1'b1;
            if (idx_step == start_q) state_d = S_IDLE;
            else                     idx_d   = idx_step;
          end
        end
        default: ;
      endcase
    end
    if (bus.EN && state_d != S_IDLE) out_d = onehot(idx_d);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      start_q <= '0;
      dwell_q <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      dwell_q <= dwell_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  dwell_counter #(.DwellWidth(DwellWidth)) u_dwell (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (state_q == S_SCAN && bus.EN),
    .zero     (cnt_zero)
  );

  assign bus.READY = ready;
  assign bus.OUT   = out_q;
  assign bus.IDX   = idx_q;
  assign bus.ERR   = err_q;
endmodule

// File: tb/tb_decoder_seq_n.sv
// Directed bench: 16-line instance for modes/scan/reset, 10-line instance for illegal commands.
module tb_decoder_seq_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  decoder_seq_n_if #(.EncodeWidth(4), .DecodeWidth(16), .DwellWidth(8)) b16 ();
  decoder_seq_n_if #(.EncodeWidth(4), .DecodeWidth(10), .DwellWidth(8)) b10 ();

  decoder_seq_n #(.EncodeWidth(4), .DecodeWidth(16), .DwellWidth(8)) dut16 (
    .CLK(clk), .RST(rst), .bus(b16)
  );
  decoder_seq_n #(.EncodeWidth(4), .DecodeWidth(10), .DwellWidth(8)) dut10 (
    .CLK(clk), .RST(rst), .bus(b10)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd16(input logic [3:0] code, input logic [1:0] mode, input logic [7:0] dwell);
    b16.IN = code; b16.MODE = mode; b16.DWELL = dwell; b16.VALID = 1'b1;
    tick();
    b16.VALID = 1'b0;
  endtask

  task automatic cmd10(input logic [3:0] code, input logic [1:0] mode);
    b10.IN = code; b10.MODE = mode; b10.DWELL = '0; b10.VALID = 1'b1;
    tick();
    b10.VALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int line;
    b16.IN = '0; b16.MODE = '0; b16.DWELL = '0; b16.VALID = 1'b0; b16.EN = 1'b1;
    b10.IN = '0; b10.MODE = '0; b10.DWELL = '0; b10.VALID = 1'b0; b10.EN = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check_val("rst_out",   32'(b16.OUT),   32'h0);
    check_val("rst_idx",   32'(b16.IDX),   32'h0);
    check_val("rst_ready", 32'(b16.READY), 32'h1);
    check_val("rst_err",   32'(b16.ERR),   32'h0);

    // level mode with EN gating
    cmd16(4'd5, 2'd0, 8'd0);
    check_val("lvl_out",  32'(b16.OUT), 32'h0020);
    check_val("lvl_idx",  32'(b16.IDX), 32'h5);
    tick();
    check_val("lvl_hold", 32'(b16.OUT), 32'h0020);
    b16.EN = 1'b0;
    tick();
    check_val("lvl_en0",  32'(b16.OUT), 32'h0);
    b16.EN = 1'b1;
    tick();
    check_val("lvl_en1",  32'(b16.OUT), 32'h0020);

    // back-to-back pulses
    b16.MODE = 2'd1; b16.VALID = 1'b1;
    b16.IN = 4'd1; tick();
    check_val("pls_1", 32'(b16.OUT), 32'h0002);
    b16.IN = 4'd2; tick();
    check_val("pls_2", 32'(b16.OUT), 32'h0004);
    b16.IN = 4'd3; tick();
    check_val("pls_3", 32'(b16.OUT), 32'h0008);
    b16.VALID = 1'b0;
    tick();
    check_val("pls_end", 32'(b16.OUT), 32'h0);

    // full scan lap from line 14, two cycles per line
    cmd16(4'd14, 2'd2, 8'd1);
    for (int k = 0; k < 32; k++) begin
      line = (14 + k / 2) % 16;
      check_val($sformatf("scan_out%0d", k), b16.OUT, 32'h1 << line);
      check_val($sformatf("scan_rdy%0d", k), 32'(b16.READY), 32'h0);
      tick();
    end
    check_val("scan_end_rdy", 32'(b16.READY), 32'h1);
    check_val("scan_end_out", 32'(b16.OUT),   32'h0);

    // same lap with EN dropped for three edges
    cmd16(4'd14, 2'd2, 8'd1);
    c = 0;
    while (b16.READY == 1'b0 && c < 100) begin
      if (c == 10) b16.EN = 1'b0;
      if (c == 12) check_val("pause_out", 32'(b16.OUT), 32'h0);
      if (c == 13) b16.EN = 1'b1;
      tick();
      c++;
    end
    check_val("pause_lap", 32'(c), 32'd35);

    // DWELL=0 advances every cycle; reset mid-scan
    cmd16(4'd3, 2'd2, 8'd0);
    tick(); tick(); tick();
    check_val("d0_out", 32'(b16.OUT), 32'h0040);
    check_val("d0_idx", 32'(b16.IDX), 32'h6);
    rst = 1'b1;
    tick();
    check_val("mid_rst_out",   32'(b16.OUT),   32'h0);
    check_val("mid_rst_idx",   32'(b16.IDX),   32'h0);
    check_val("mid_rst_ready", 32'(b16.READY), 32'h1);
    check_val("mid_rst_err",   32'(b16.ERR),   32'h0);
    rst = 1'b0;
    tick();

    // illegal commands on the 10-line instance
    cmd10(4'd7, 2'd0);
    check_val("e_lvl_out", 32'(b10.OUT), 32'h080);
    cmd10(4'd12, 2'd0);
    check_val("e_rng_err", 32'(b10.ERR), 32'h1);
    check_val("e_rng_out", 32'(b10.OUT), 32'h0);
    check_val("e_rng_idx", 32'(b10.IDX), 32'h7);
    tick();
    check_val("e_rng_err_clr", 32'(b10.ERR), 32'h0);
    cmd10(4'd9, 2'd0);
    check_val("e_max_out", 32'(b10.OUT), 32'h200);
    check_val("e_max_err", 32'(b10.ERR), 32'h0);
    cmd10(4'd10, 2'd1);
    check_val("e_lim_err", 32'(b10.ERR), 32'h1);
    check_val("e_lim_idx", 32'(b10.IDX), 32'h9);
    cmd10(4'd2, 2'd3);
    check_val("e_rsv_err", 32'(b10.ERR), 32'h1);
    check_val("e_rsv_out", 32'(b10.OUT), 32'h0);
    check_val("e_rsv_idx", 32'(b10.IDX), 32'h9);
    tick();
    check_val("e_rsv_clr", 32'(b10.ERR), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
